// File: rtl/sha256_compress_core.sv
// SHA-256 compression core: 64 rounds on a..h, one round per accepted W[t] word,
// then folds the working registers into the chaining value H0..H7.
// Define SHA224_EN to use the SHA-224 IV and zero digest[31:0].
module sha256_compress_core #(
    parameter int unsigned ROUNDS      = 64,
    parameter int unsigned DIGEST_HOLD = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         block_start,
    input  logic         first_block,
    input  logic [31:0]  wt,
    input  logic         wt_valid,
    output logic         busy,
    output logic [5:0]   round_idx,
    output logic         digest_valid,
    output logic [255:0] digest
);

    typedef enum logic [1:0] {StIdle, StLoad, StRound, StFinal} state_e;

`ifdef SHA224_EN
    localparam logic [31:0] HashIv [8] = '{
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };
`else
    localparam logic [31:0] HashIv [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
`endif

    localparam logic [5:0] LastRound = 6'(ROUNDS - 1);

    function automatic logic [31:0] ror(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] k_rom(input logic [5:0] idx);
        logic [31:0] k;
        k = 32'h0;
        case (idx)
            6'd0:  k = 32'h428a2f98;  6'd1:  k = 32'h71374491;
            6'd2:  k = 32'hb5c0fbcf;  6'd3:  k = 32'he9b5dba5;
            6'd4:  k = 32'h3956c25b;  6'd5:  k = 32'h59f111f1;
            6'd6:  k = 32'h923f82a4;  6'd7:  k = 32'hab1c5ed5;
            6'd8:  k = 32'hd807aa98;  6'd9:  k = 32'h12835b01;
            6'd10: k = 32'h243185be;  6'd11: k = 32'h550c7dc3;
            6'd12: k = 32'h72be5d74;  6'd13: k = 32'h80deb1fe;
            6'd14: k = 32'h9bdc06a7;  6'd15: k = 32'hc19bf174;
            6'd16: k = 32'he49b69c1;  6'd17: k = 32'hefbe4786;
            6'd18: k = 32'h0fc19dc6;  6'd19: k = 32'h240ca1cc;
            6'd20: k = 32'h2de92c6f;  6'd21: k = 32'h4a7484aa;
            6'd22: k = 32'h5cb0a9dc;  6'd23: k = 32'h76f988da;
            6'd24: k = 32'h983e5152;  6'd25: k = 32'ha831c66d;
            6'd26: k = 32'hb00327c8;  6'd27: k = 32'hbf597fc7;
            6'd28: k = 32'hc6e00bf3;  6'd29: k = 32'hd5a79147;
            6'd30: k = 32'h06ca6351;  6'd31: k = 32'h14292967;
            6'd32: k = 32'h27b70a85;  6'd33: k = 32'h2e1b2138;
            6'd34: k = 32'h4d2c6dfc;  6'd35: k = 32'h53380d13;
            6'd36: k = 32'h650a7354;  6'd37: k = 32'h766a0abb;
            6'd38: k = 32'h81c2c92e;  6'd39: k = 32'h92722c85;
            6'd40: k = 32'ha2bfe8a1;  6'd41: k = 32'ha81a664b;
            6'd42: k = 32'hc24b8b70;  6'd43: k = 32'hc76c51a3;
            6'd44: k = 32'hd192e819;  6'd45: k = 32'hd6990624;
            6'd46: k = 32'hf40e3585;  6'd47: k = 32'h106aa070;
            6'd48: k = 32'h19a4c116;  6'd49: k = 32'h1e376c08;
            6'd50: k = 32'h2748774c;  6'd51: k = 32'h34b0bcb5;
            6'd52: k = 32'h391c0cb3;  6'd53: k = 32'h4ed8aa4a;
            6'd54: k = 32'h5b9cca4f;  6'd55: k = 32'h682e6ff3;
            6'd56: k = 32'h748f82ee;  6'd57: k = 32'h78a5636f;
            6'd58: k = 32'h84c87814;  6'd59: k = 32'h8cc70208;
            6'd60: k = 32'h90befffa;  6'd61: k = 32'ha4506ceb;
            6'd62: k = 32'hbef9a3f7;  6'd63: k = 32'hc67178f2;
            default: k = 32'h0;
        endcase
        return k;
    endfunction

    state_e      state_q, state_d;
    logic        busy_q, busy_d;
    logic        valid_q, valid_d;
    logic [5:0]  round_q, round_d;
    logic [31:0] work_q [8];  // a..h
    logic [31:0] work_d [8];
    logic [31:0] hash_q [8];  // H0..H7
    logic [31:0] hash_d [8];
    logic [31:0] t1, t2;

    // Round function on the current a..h, K[round_idx] and W[round_idx].
    always_comb begin
        t1 = work_q[7]
           + (ror(work_q[4], 6) ^ ror(work_q[4], 11) ^ ror(work_q[4], 25))
           + ((work_q[4] & work_q[5]) ^ (~work_q[4] & work_q[6]))
           + k_rom(round_q) + wt;
        t2 = (ror(work_q[0], 2) ^ ror(work_q[0], 13) ^ ror(work_q[0], 22))
           + ((work_q[0] & work_q[1]) ^ (work_q[0] & work_q[2]) ^ (work_q[1] & work_q[2]));
    end

    // Next-state: IDLE -> LOAD -> ROUND (stalls without wt_valid) -> FINAL -> IDLE.
    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        round_d = round_q;
        work_d  = work_q;
        hash_d  = hash_q;
        valid_d = (DIGEST_HOLD != 0) ? valid_q : 1'b0;
        unique case (state_q)
            StIdle: begin
                if (block_start) begin
                    state_d = StLoad;
                    busy_d  = 1'b1;
                    valid_d = 1'b0;
                    if (first_block) hash_d = HashIv;
                end
            end
            StLoad: begin
                work_d  = hash_q;
                round_d = 6'd0;
                state_d = StRound;
            end
            StRound: begin
                if (wt_valid) begin
                    for (int i = 1; i < 8; i++) work_d[i] = work_q[i-1];
                    work_d[4] = work_q[3] + t1;
                    work_d[0] = t1 + t2;
                    if (round_q == LastRound) begin
                        round_d = 6'd0;
                        state_d = StFinal;
                    end else begin
                        round_d = round_q + 6'd1;
                    end
                end
            end
            StFinal: begin
                for (int i = 0; i < 8; i++) hash_d[i] = hash_q[i] + work_q[i];
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            round_q <= 6'd0;
            for (int i = 0; i < 8; i++) begin
                work_q[i] <= 32'h0;
                hash_q[i] <= HashIv[i];
            end
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            round_q <= round_d;
            work_q  <= work_d;
            hash_q  <= hash_d;
        end
    end

    // Outputs come straight from registers; the digest is the chaining value.
    always_comb begin
        busy         = busy_q;
        round_idx    = round_q;
        digest_valid = valid_q;
`ifdef SHA224_EN
        digest = {hash_q[0], hash_q[1], hash_q[2], hash_q[3],
                  hash_q[4], hash_q[5], hash_q[6], 32'h0};
`else
        digest = {hash_q[0], hash_q[1], hash_q[2], hash_q[3],
                  hash_q[4], hash_q[5], hash_q[6], hash_q[7]};
`endif
    end

endmodule

// File: tb/tb_sha256_compress_core.sv
// Bench for sha256_compress_core: known-answer blocks plus randomized blocks, stalls and
// ignored block_start pulses, checked against a message-level SHA-256 model.
module tb_sha256_compress_core;

    typedef logic [31:0] block_t [16];
    typedef logic [31:0] sched_t [64];

    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
        32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
        32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
        32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
        32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
        32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

`ifdef SHA224_EN
    localparam logic [255:0] IV =
        256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;
`else
    localparam logic [255:0] IV =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         block_start;
    logic         first_block;
    logic [31:0]  wt;
    logic         wt_valid;
    logic         busy;
    logic [5:0]   round_idx;
    logic         digest_valid;
    logic [255:0] digest;

    int           n_checks = 0;
    int           n_errors = 0;
    logic [255:0] h_model;

    always #5 clk = ~clk;

    sha256_compress_core dut (
        .clk          (clk),
        .reset        (reset),
        .block_start  (block_start),
        .first_block  (first_block),
        .wt           (wt),
        .wt_valid     (wt_valid),
        .busy         (busy),
        .round_idx    (round_idx),
        .digest_valid (digest_valid),
        .digest       (digest)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Message schedule, as the upstream scheduler would produce it.
    task automatic expand(input block_t blk, output sched_t w);
        for (int t = 0; t < 64; t++) begin
            if (t < 16) w[t] = blk[t];
            else w[t] = (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                      + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
        end
    endtask

    function automatic logic [255:0] compress(input logic [255:0] hin, input sched_t w);
        logic [31:0]  v [8];
        logic [31:0]  x1, x2;
        logic [255:0] hout;
        for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
        for (int t = 0; t < 64; t++) begin
            x1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K_TAB[t] + w[t];
            x2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[4] = v[4] + x1;
            v[0] = x1 + x2;
        end
        for (int i = 0; i < 8; i++) hout[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + v[i];
        return hout;
    endfunction

    function automatic logic [255:0] digest_of(input logic [255:0] h);
`ifdef SHA224_EN
        return {h[255:32], 32'h0};
`else
        return h;
`endif
    endfunction

    // Starts a block at the current negedge and feeds it; returns at the negedge where
    // digest_valid is seen (lat = edges after the block_start edge), or asserts reset at
    // negedge abort_k (lat = -1).
    task automatic run_block(input block_t blk, input bit first, input int stall_pct,
                             input logic [63:0] stall_mask, input int abort_k,
                             input bit pulses, output int lat);
        sched_t       w;
        bit           used [64];
        int           cons;
        int           exp_done;
        bit           done;
        logic [255:0] h_pre, h_post;
        expand(blk, w);
        for (int i = 0; i < 64; i++) used[i] = 1'b0;
        h_pre  = first ? IV : h_model;
        h_post = compress(h_pre, w);
        cons = 0; exp_done = -1; done = 1'b0; lat = -1;
        block_start = 1'b1; first_block = first; wt = $urandom; wt_valid = 1'b1;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk);
            block_start = 1'b0;
            first_block = 1'($urandom);
            if (k == abort_k) begin
                reset = 1'b1; wt_valid = 1'b0; done = 1'b1;
                h_model = IV;
            end else if (digest_valid) begin
                lat = k; done = 1'b1;
                check("digest", digest, digest_of(h_post));
                check("latency", 256'(k), 256'(exp_done));
                check("busy_done", 256'(busy), 256'(0));
                h_model = h_post;
            end else begin
                if (k == 0) begin
                    check("dv_clear", 256'(digest_valid), 256'(0));
                    check("busy_load", 256'(busy), 256'(1));
                    check("digest_pre", digest, digest_of(h_pre));
                end
                if (pulses && k >= 1 && $urandom_range(0, 7) == 0) begin
                    block_start = 1'b1; first_block = 1'b1;
                end
                if (k >= 1 && cons < 64) begin
                    check("round_idx", 256'(round_idx), 256'(cons));
                    wt = w[cons];
                    if (stall_mask[cons] && !used[cons]) begin
                        used[cons] = 1'b1; wt_valid = 1'b0;
                    end else begin
                        wt_valid = ($urandom_range(0, 99) >= stall_pct);
                    end
                    if (!wt_valid) wt = $urandom;
                    if (wt_valid) begin
                        cons++;
                        if (cons == 64) exp_done = k + 2;
                    end
                end else begin
                    wt = $urandom; wt_valid = 1'($urandom);
                end
            end
        end
        if (!done) check("timeout", 256'(0), 256'(1));
    endtask

    initial begin
        block_t blk_abc, blk_empty, blk_m1, blk_m2, blk;
        int     lat;
        reset = 1'b1; block_start = 1'b0; first_block = 1'b0; wt = '0; wt_valid = 1'b0;
        h_model = IV;
        for (int i = 0; i < 16; i++) begin
            blk_abc[i] = '0; blk_empty[i] = '0; blk_m2[i] = '0;
        end
        blk_abc[0] = 32'h61626380; blk_abc[15] = 32'h18;
        blk_empty[0] = 32'h80000000;
        for (int i = 0; i < 14; i++)
            blk_m1[i] = {8'h61 + 8'(i), 8'h62 + 8'(i), 8'h63 + 8'(i), 8'h64 + 8'(i)};
        blk_m1[14] = 32'h80000000; blk_m1[15] = 32'h0;
        blk_m2[15] = 32'h1c0;

        repeat (3) @(negedge clk);
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_round", 256'(round_idx), 256'(0));
        check("rst_dv", 256'(digest_valid), 256'(0));
        check("rst_digest", digest, digest_of(IV));
        reset = 1'b0;
        @(negedge clk);

        // T1 / T6: "abc", no stalls
        run_block(blk_abc, 1'b1, 0, 64'h0, -1, 1'b0, lat);
        check("t1_cycle", 256'(lat), 256'(66));
`ifdef SHA224_EN
        check("t6_digest", digest,
              {224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, 32'h0});
`else
        check("t1_digest", digest,
              256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);
`endif
        @(negedge clk);
        check("t1_dv_pulse", 256'(digest_valid), 256'(0));

        // T2: empty string
        run_block(blk_empty, 1'b1, 0, 64'h0, -1, 1'b0, lat);
`ifndef SHA224_EN
        check("t2_digest", digest,
              256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855);
`endif

        // T3: two-block message, second block started in the digest_valid cycle
        run_block(blk_m1, 1'b1, 0, 64'h0, -1, 1'b0, lat);
        run_block(blk_m2, 1'b0, 0, 64'h0, -1, 1'b0, lat);
`ifndef SHA224_EN
        check("t3_digest", digest,
              256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1);
`endif
        @(negedge clk);

        // T4: stalls on rounds 0, 31, 63 and stray block_start pulses while busy
        run_block(blk_abc, 1'b1, 0, 64'h8000_0000_8000_0001, -1, 1'b1, lat);
        check("t4_cycle", 256'(lat), 256'(69));
        @(negedge clk);

        // T5: reset at round 20 aborts the block
        run_block(blk_abc, 1'b1, 0, 64'h0, 21, 1'b0, lat);
        repeat (2) begin
            @(negedge clk);
            check("t5_dv_in_reset", 256'(digest_valid), 256'(0));
        end
        reset = 1'b0;
        check("t5_digest_iv", digest, digest_of(IV));
        check("t5_busy", 256'(busy), 256'(0));
        check("t5_round", 256'(round_idx), 256'(0));
        repeat (80) begin
            @(negedge clk);
            wt = $urandom; wt_valid = 1'($urandom);
            check("t5_no_dv", 256'(digest_valid), 256'(0));
        end
        check("t5_digest_hold", digest, digest_of(IV));
        run_block(blk_abc, 1'b1, 0, 64'h0, -1, 1'b0, lat);
`ifndef SHA224_EN
        check("t5_digest", digest,
              256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);
`endif

        // Randomized chained blocks with random stalls, gaps and stray pulses
        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < 16; i++) blk[i] = $urandom;
            run_block(blk, ($urandom_range(0, 3) == 0), 15, 64'h0, -1, 1'b1, lat);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) begin
                    @(negedge clk);
                    wt = $urandom; wt_valid = 1'($urandom);
                    check("idle_dv", 256'(digest_valid), 256'(0));
                    check("idle_digest", digest, digest_of(h_model));
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
